// File: rtl/chien_search.sv
// Chien search for RS(255,239): evaluates sigma, x*sigma'(x) and omega at x_k = alpha^(k+1),
// one point per clock, highest codeword position first, and feeds the Forney stage.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start; outputs hold, done low
// RUN   | one evaluation per clock, N clocks
// DONE  | one-cycle done pulse, fail computed, back to IDLE
module chien_search #(
    parameter int T = 8,
    parameter int N = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [8*(T+1)-1:0] sigma_in,
    input  logic [8*T-1:0]     omega_in,
    output logic               busy,
    output logic               valid,
    output logic               first,
    output logic               last,
    output logic [7:0]         sigma_out,
    output logic [7:0]         dsigma_out,
    output logic [7:0]         omega_out,
    output logic               done,
    output logic [7:0]         err_count,
    output logic               fail
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] CNT_INIT = 8'(N - 1);

    state_t     state, state_nxt;
    logic [7:0] rs     [0:T];
    logic [7:0] ro     [0:T-1];
    logic [7:0] rs_nxt [0:T];
    logic [7:0] ro_nxt [0:T-1];
    logic [7:0] rs_ld  [0:T];
    logic [7:0] ro_ld  [0:T-1];
    logic [7:0] cnt;
    logic [4:0] deg, deg_in;
    logic       sigma0_zero;
    logic [7:0] sig_sum, dsig_sum, om_sum;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1d : 8'h00);
    endfunction

    function automatic logic [7:0] mul_apow(input logic [7:0] a, input int p);
        logic [7:0] r;
        r = a;
        for (int i = 0; i < p; i++) r = xtime(r);
        return r;
    endfunction

    // Constant multipliers by alpha^j, one per coefficient tap.
    for (genvar gj = 0; gj <= T; gj++) begin : g_sigma_tap
        assign rs_nxt[gj] = mul_apow(rs[gj], gj);
        assign rs_ld[gj]  = mul_apow(sigma_in[8*gj +: 8], gj);
    end

    for (genvar gj = 0; gj < T; gj++) begin : g_omega_tap
        assign ro_nxt[gj] = mul_apow(ro[gj], gj);
        assign ro_ld[gj]  = mul_apow(omega_in[8*gj +: 8], gj);
    end

    always_comb begin
        sig_sum  = 8'h00;
        dsig_sum = 8'h00;
        om_sum   = 8'h00;
        deg_in   = 5'd0;
        for (int j = 0; j <= T; j++) begin
            sig_sum = sig_sum ^ rs[j];
            if ((j % 2) == 1) dsig_sum = dsig_sum ^ rs[j];
            if (sigma_in[8*j +: 8] != 8'h00) deg_in = 5'(j);
        end
        for (int j = 0; j < T; j++) om_sum = om_sum ^ ro[j];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 8'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j <= T; j++) rs[j] <= 8'h00;
            for (int j = 0; j < T; j++)  ro[j] <= 8'h00;
            cnt         <= 8'd0;
            deg         <= 5'd0;
            sigma0_zero <= 1'b0;
            busy        <= 1'b0;
            valid       <= 1'b0;
            first       <= 1'b0;
            last        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            err_count   <= 8'd0;
            sigma_out   <= 8'h00;
            dsigma_out  <= 8'h00;
            omega_out   <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    valid <= 1'b0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        for (int j = 0; j <= T; j++) rs[j] <= rs_ld[j];
                        for (int j = 0; j < T; j++)  ro[j] <= ro_ld[j];
                        deg         <= deg_in;
                        sigma0_zero <= (sigma_in[7:0] == 8'h00);
                        cnt         <= CNT_INIT;
                        err_count   <= 8'd0;
                        fail        <= 1'b0;
                        busy        <= 1'b1;
                    end
                end
                RUN: begin
                    sigma_out  <= sig_sum;
                    dsigma_out <= dsig_sum;
                    omega_out  <= om_sum;
                    for (int j = 0; j <= T; j++) rs[j] <= rs_nxt[j];
                    for (int j = 0; j < T; j++)  ro[j] <= ro_nxt[j];
                    valid <= 1'b1;
                    first <= (cnt == CNT_INIT);
                    last  <= (cnt == 8'd0);
                    if (sig_sum == 8'h00 && err_count != 8'hff)
                        err_count <= err_count + 8'd1;
                    cnt <= cnt - 8'd1;
                end
                DONE: begin
                    valid <= 1'b0;
                    first <= 1'b0;
                    last  <= 1'b0;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    fail  <= (err_count != {3'b000, deg}) || sigma0_zero;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chien_search.sv
// Self-checking bench for chien_search: a direct polynomial-evaluation model fills a
// scoreboard at each start; a negedge monitor pops and compares every valid output.
module tb_chien_search;
    localparam int T = 8;
    localparam int N = 255;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               start = 1'b0;
    logic [8*(T+1)-1:0] sigma_in = '0;
    logic [8*T-1:0]     omega_in = '0;
    logic               busy, valid, first, last, done, fail;
    logic [7:0]         sigma_out, dsigma_out, omega_out, err_count;

    chien_search #(.T(T), .N(N)) dut (
        .clk(clk), .reset(reset), .start(start),
        .sigma_in(sigma_in), .omega_in(omega_in),
        .busy(busy), .valid(valid), .first(first), .last(last),
        .sigma_out(sigma_out), .dsigma_out(dsigma_out), .omega_out(omega_out),
        .done(done), .err_count(err_count), .fail(fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] sg;
        logic [7:0] ds;
        logic [7:0] om;
        logic       f;
        logic       l;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] s_coef [0:T];
    logic [7:0] o_coef [0:T-1];
    int         n_total = 0;
    int         n_pass = 0;
    int         n_valid = 0;
    int         n_done = 0;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, aa;
        r  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1d : 8'h00);
        end
        return r;
    endfunction

    function automatic exp_t model(input int k);
        exp_t       e;
        logic [7:0] x, xp, term;
        x = 8'h01;
        for (int i = 0; i <= k; i++) x = gf_mul(x, 8'h02);
        e.sg = 8'h00; e.ds = 8'h00; e.om = 8'h00;
        xp = 8'h01;
        for (int j = 0; j <= T; j++) begin
            term = gf_mul(s_coef[j], xp);
            e.sg = e.sg ^ term;
            if ((j % 2) == 1) e.ds = e.ds ^ term;
            if (j < T) e.om = e.om ^ gf_mul(o_coef[j], xp);
            xp = gf_mul(xp, x);
        end
        e.f = (k == 0);
        e.l = (k == N - 1);
        return e;
    endfunction

    always @(negedge clk) begin
        if (reset && done) n_done++;
        if (reset && valid) begin
            exp_t e;
            n_valid++;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_empty: valid with no expectation, sigma_out=%h", sigma_out);
            end else begin
                e = exp_q.pop_front();
                if ({sigma_out, dsigma_out, omega_out, first, last} !== {e.sg, e.ds, e.om, e.f, e.l})
                    $display("FAIL eval: got s=%h ds=%h om=%h f=%b l=%b, want s=%h ds=%h om=%h f=%b l=%b",
                             sigma_out, dsigma_out, omega_out, first, last, e.sg, e.ds, e.om, e.f, e.l);
                else
                    n_pass++;
            end
        end
    end

    task automatic set_coefs(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] o0);
        for (int j = 0; j <= T; j++) s_coef[j] = 8'h00;
        for (int j = 0; j < T; j++)  o_coef[j] = 8'h00;
        s_coef[0] = s0; s_coef[1] = s1; s_coef[2] = s2; o_coef[0] = o0;
    endtask

    task automatic load_and_push();
        for (int j = 0; j <= T; j++) sigma_in[8*j +: 8] = s_coef[j];
        for (int j = 0; j < T; j++)  omega_in[8*j +: 8] = o_coef[j];
        for (int k = 0; k < N; k++) exp_q.push_back(model(k));
    endtask

    task automatic launch();
        load_and_push();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic run_to_done(output int cyc);
        cyc = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done) return;
        end
        cyc = -1;
    endtask

    task automatic finish_checks(input string name, input logic [7:0] exp_err, input logic exp_fail);
        int cyc, v0, d0;
        v0 = n_valid;
        d0 = n_done;
        run_to_done(cyc);
        n_total++;
        if (cyc !== 256) $display("FAIL %s_done_cycle: got %0d want 256", name, cyc);
        else n_pass++;
        n_total++;
        if ({err_count, fail, busy, valid} !== {exp_err, exp_fail, 1'b0, 1'b0})
            $display("FAIL %s_result: got err=%0d fail=%b busy=%b valid=%b want err=%0d fail=%b busy=0 valid=0",
                     name, err_count, fail, busy, valid, exp_err, exp_fail);
        else n_pass++;
        @(posedge clk);
        #1;
        n_total++;
        if ({done, err_count, fail} !== {1'b0, exp_err, exp_fail} || exp_q.size() != 0)
            $display("FAIL %s_hold: got done=%b err=%0d fail=%b left=%0d want done=0 err=%0d fail=%b left=0",
                     name, done, err_count, fail, exp_q.size(), exp_err, exp_fail);
        else n_pass++;
        n_total++;
        if (n_valid - v0 != 255 || n_done - d0 != 1)
            $display("FAIL %s_counts: got valids=%0d dones=%0d want 255 and 1", name, n_valid - v0, n_done - d0);
        else n_pass++;
    endtask

    task automatic test_reset();
        start = 1'b1;
        #1;
        n_total++;
        if ({busy, valid, first, last, done, fail, sigma_out, dsigma_out, omega_out, err_count} !== '0)
            $display("FAIL reset_outputs: got busy=%b valid=%b done=%b err=%h want all 0", busy, valid, done, err_count);
        else n_pass++;
        repeat (3) @(posedge clk);
        @(negedge clk) start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_total++;
        if ({busy, valid, done} !== 3'b000)
            $display("FAIL reset_start_ignored: got busy=%b valid=%b done=%b want 000", busy, valid, done);
        else n_pass++;
    endtask

    task automatic test_no_error();
        set_coefs(8'h01, 8'h00, 8'h00, 8'h00);
        launch();
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL no_error_busy: got %b want 1", busy);
        else n_pass++;
        finish_checks("no_error", 8'd0, 1'b0);
    endtask

    task automatic test_single_error();
        set_coefs(8'h01, 8'h74, 8'h00, 8'h00);
        launch();
        finish_checks("single_error", 8'd1, 1'b0);
    endtask

    task automatic test_double_root();
        set_coefs(8'h01, 8'h00, 8'h01, 8'h00);
        launch();
        finish_checks("double_root", 8'd1, 1'b1);
    endtask

    task automatic test_omega_and_fail();
        set_coefs(8'h01, 8'h00, 8'h00, 8'h05);
        launch();
        finish_checks("omega", 8'd0, 1'b0);
        set_coefs(8'h00, 8'h01, 8'h00, 8'h00);
        launch();
        finish_checks("sigma0_zero", 8'd0, 1'b1);
        set_coefs(8'h00, 8'h00, 8'h00, 8'h00);
        launch();
        finish_checks("saturate", 8'd255, 1'b1);
    endtask

    task automatic test_back_to_back();
        int d0, v0;
        logic seen_done;
        seen_done = 1'b0;
        set_coefs(8'h01, 8'h74, 8'h00, 8'h00);
        d0 = n_done;
        v0 = n_valid;
        launch();
        for (int c = 1; c <= 520 && !seen_done; c++) begin
            @(posedge clk);
            #1;
            if (c == 100) begin
                sigma_in = {(T+1){8'ha5}};
                start = 1'b1;
            end
            if (c == 101) start = 1'b0;
            if (c == 255) start = 1'b1;
            if (c == 256) begin
                n_total++;
                if ({done, valid, n_valid - v0, n_done - d0} !== {1'b1, 1'b0, 32'd255, 32'd0})
                    $display("FAIL b2b_first_done: got done=%b valid=%b valids=%0d want done=1 valid=0 valids=255",
                             done, valid, n_valid - v0);
                else n_pass++;
                set_coefs(8'h01, 8'h00, 8'h01, 8'h00);
                load_and_push();
            end
            if (c == 257) begin
                start = 1'b0;
                n_total++;
                if ({busy, done} !== 2'b10) $display("FAIL b2b_accept: got busy=%b done=%b want 1 0", busy, done);
                else n_pass++;
            end
            if (c == 258) begin
                n_total++;
                if ({valid, first} !== 2'b11) $display("FAIL b2b_first: got valid=%b first=%b want 1 1", valid, first);
                else n_pass++;
            end
            if (done && c > 257) begin
                seen_done = 1'b1;
                n_total++;
                if (c != 513 || {err_count, fail} !== {8'd1, 1'b1} || n_done - d0 != 1)
                    $display("FAIL b2b_second_done: got cycle=%0d err=%0d fail=%b dones=%0d want 513 1 1 1",
                             c, err_count, fail, n_done - d0);
                else n_pass++;
            end
        end
        if (!seen_done) begin
            n_total++;
            $display("FAIL b2b_timeout: got no second done want done at 513");
        end
        @(posedge clk);
        #1;
        n_total++;
        if (n_done - d0 != 2 || exp_q.size() != 0)
            $display("FAIL b2b_totals: got dones=%0d left=%0d want 2 0", n_done - d0, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int d0;
        set_coefs(8'h01, 8'h74, 8'h00, 8'h00);
        launch();
        repeat (50) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        n_total++;
        if ({busy, valid, first, last, done, fail, sigma_out, dsigma_out, omega_out, err_count} !== '0)
            $display("FAIL midrun_reset: got busy=%b valid=%b sigma_out=%h err=%h want all 0",
                     busy, valid, sigma_out, err_count);
        else n_pass++;
        exp_q.delete();
        d0 = n_done;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        n_total++;
        if ({busy, valid, done} !== 3'b000 || n_done != d0)
            $display("FAIL midrun_no_done: got busy=%b valid=%b dones=%0d want 0 0 0", busy, valid, n_done - d0);
        else n_pass++;
        launch();
        finish_checks("after_reset", 8'd1, 1'b0);
    endtask

    initial begin
        for (int j = 0; j <= T; j++) s_coef[j] = 8'h00;
        for (int j = 0; j < T; j++)  o_coef[j] = 8'h00;
        test_reset();
        test_no_error();
        test_single_error();
        test_double_root();
        test_omega_and_fail();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chien_search.md
Name: chien_search

Overview:
- GF(2^8) Chien search engine for the RS(255,239) Euclidean decoder.
- Sits between the key-equation solver, which supplies sigma(x) and omega(x), and the Forney error evaluator.
- Once loaded, it evaluates sigma, its odd-term part and omega at one field point per clock, in received-symbol order (highest position first).
- Its per-cycle outputs feed the Forney stage directly:
  - sigma_out drives Forney's sigma.
  - dsigma_out drives Forney's dsigma.
  - omega_out drives Forney's sum.

Parameters:
- T, 8, correction capability; sigma has T+1 coefficients, omega has T (legal range 1..16).
- N, 255, number of positions evaluated per codeword (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle load strobe; honoured only when busy=0.
- sigma_in  input  8*(T+1)  sigma_j at bits [8j+7:8j], j=0..T.
- omega_in  input  8*T  omega_j at bits [8j+7:8j], j=0..T-1.
- busy  output  1  search in progress.
- valid  output  1  evaluation outputs valid this cycle.
- first  output  1  with valid, position N-1 (k=0).
- last  output  1  with valid, final position (k=N-1).
- sigma_out  output  8  sigma(x_k).
- dsigma_out  output  8  sum over odd j of sigma_j·x_k^j, i.e. x·sigma'(x).
- omega_out  output  8  omega(x_k).
- done  output  1  one-cycle pulse after the last evaluation.
- err_count  output  8  number of k with sigma(x_k)=0; final value when done=1.
- fail  output  1  decoder-failure flag; qualified by done.

Behaviour:
- Field arithmetic:
  - Primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha=0x02.
  - Addition is XOR.
  - All multipliers are constant multipliers by alpha^j.
- Evaluation point: x_k = alpha^(k+1), k=0..N-1, which corresponds to codeword position p=254-k (root of an error at p is alpha^-p).
- Reset (async, reset=0):
  - FSM goes to IDLE.
  - All outputs are 0: busy, valid, first, last, done, fail, sigma_out, dsigma_out, omega_out, err_count.
  - Coefficient registers and the counter are cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0 loads Rs_j <= sigma_j·alpha^j and Ro_j <= omega_j·alpha^j.
  - Latches deg = highest j with sigma_j≠0 (0 if none).
  - Clears k and err_count; sets busy=1; goes to RUN.
- RUN: at each edge E1..EN (k = 0..N-1):
  - sigma_out <= XOR of Rs_j.
  - dsigma_out <= XOR of Rs_j over odd j.
  - omega_out <= XOR of Ro_j.
  - Rs_j <= Rs_j·alpha^j and Ro_j <= Ro_j·alpha^j.
  - valid <= 1; first <= (k==0); last <= (k==N-1).
  - err_count increments when the value being registered into sigma_out is 0.
  - Latency: the start edge plus one cycle, so the first valid output appears after edge E1.
- Transition at EN: RUN to DONE.
- DONE: at edge EN+1:
  - valid <= 0; done <= 1 for exactly one cycle; busy <= 0.
  - fail <= (err_count≠deg) OR (sigma_0==0).
  - FSM returns to IDLE.
- Hold behaviour:
  - err_count and fail hold their values until the next accepted start.
  - sigma_out, dsigma_out and omega_out hold their last values when valid=0.
- Boundary conditions:
  - start while busy=1 (including the DONE cycle) is ignored, with no effect on registers.
  - The earliest new start is accepted at edge EN+2, giving back-to-back codewords.
  - A repeated root counts once per position; the degree mismatch then raises fail.
  - err_count saturates at 255.
  - Reset mid-RUN aborts immediately to the reset state; no done pulse is issued.
  - start asserted while reset=0 is ignored.
- Constraint: no other state may alter coefficient registers during RUN; sigma_in and omega_in are sampled only at the accepted start edge.

Test Plan:
1. Reset then start, sigma_0=0x01 (all other sigma_j=0), omega all 0 -> 255 valid cycles with sigma_out=0x01, dsigma_out=0x00, omega_out=0x00; first at k=0, last at k=254; done pulse at edge E256 with err_count=0, fail=0.
2. Single error, sigma_0=0x01, sigma_1=0x74 (alpha^10) -> sigma_out=0x00 only at k=244 (position 10), with dsigma_out=0x01 at that k; err_count=1, fail=0.
3. Double root, sigma_0=0x01, sigma_2=0x01 -> sigma_out=0x00 only at k=254; err_count=1, deg=2, fail=1.
4. Omega pass-through, omega_0=0x05 (others 0), sigma_0=0x01 -> omega_out=0x05 on every valid cycle. Separately, sigma_0=0x00, sigma_1=0x01 -> fail=1.
5. Handshake: pulse start at k=100 and again during the DONE cycle -> both ignored, exactly 255 valid cycles, a single done. A start at E257 is accepted, and the second codeword has first at E258.
6. Drop reset at k=50 -> all outputs 0 asynchronously, busy=0, no done. A later start produces a full, correct 255-cycle run.
